// File: rtl/mxu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// mxu_pkg: shared defaults and FSM state encoding for systolic_mxu
// Rev 1.0
// ------------------------------------------------------------------
package mxu_pkg;

    localparam int MXU_NUM_SIZE  = 16;
    localparam int MXU_GRID_SIZE = 4;
    localparam int MXU_ACC_SIZE  = 2 * MXU_NUM_SIZE + 8;
    localparam int MXU_KLEN_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } mxu_state_e;

endpackage
`default_nettype wire

// File: rtl/mac_pe.sv
`default_nettype none
// ------------------------------------------------------------------
// mac_pe: systolic multiply-accumulate cell with operand pass-through
// Rev 1.0
// ------------------------------------------------------------------
module mac_pe
    import mxu_pkg::*;
#(
    parameter int NUM_SIZE = MXU_NUM_SIZE,
    parameter int ACC_SIZE = MXU_ACC_SIZE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ce,
    input  logic                clr,
    input  logic [NUM_SIZE-1:0] a_in,
    input  logic [NUM_SIZE-1:0] b_in,
    output logic [NUM_SIZE-1:0] a_out,
    output logic [NUM_SIZE-1:0] b_out,
    output logic [ACC_SIZE-1:0] acc_out
);

    logic signed [2*NUM_SIZE-1:0] prod;
    logic signed [ACC_SIZE-1:0]   prod_ext;
    logic [NUM_SIZE-1:0]          a_d, a_q, b_d, b_q;
    logic [ACC_SIZE-1:0]          acc_d, acc_q;

    // Operands are widened before the multiply so the full signed product is kept.
    always_comb begin
        prod     = (2*NUM_SIZE)'($signed(a_in)) * (2*NUM_SIZE)'($signed(b_in));
        prod_ext = ACC_SIZE'(prod);
        a_d      = clr ? '0 : a_in;
        b_d      = clr ? '0 : b_in;
        acc_d    = clr ? '0 : acc_q + prod_ext;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (ce) begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    assign a_out   = a_q;
    assign b_out   = b_q;
    assign acc_out = acc_q;

endmodule
`default_nettype wire

// File: rtl/systolic_mxu.sv
`default_nettype none
// ------------------------------------------------------------------
// systolic_mxu: output-stationary GRID x GRID matrix multiply unit
// Rev 1.0
// ------------------------------------------------------------------
module systolic_mxu
    import mxu_pkg::*;
#(
    parameter int NUM_SIZE  = MXU_NUM_SIZE,
    parameter int GRID_SIZE = MXU_GRID_SIZE,
    parameter int ACC_SIZE  = 2 * NUM_SIZE + 8,
    parameter int KLEN_W    = MXU_KLEN_W
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  ce,
    input  logic                                  start,
    input  logic [KLEN_W-1:0]                     k_len,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [GRID_SIZE*NUM_SIZE-1:0]         west_input,
    input  logic [GRID_SIZE*NUM_SIZE-1:0]         north_input,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [GRID_SIZE*GRID_SIZE*ACC_SIZE-1:0] result_out,
    output logic                                  busy
);

    localparam int                 DRAIN_W    = $clog2(2 * GRID_SIZE);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(2 * GRID_SIZE - 2);

    mxu_state_e          state_d, state_q;
    logic [KLEN_W-1:0]   beat_cnt_d, beat_cnt_q;
    logic [DRAIN_W-1:0]  drain_cnt_d, drain_cnt_q;
    logic                in_ready_q, out_valid_q, busy_q;
    logic                clr;
    logic                beat;

    assign beat = in_ready_q && in_valid;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        drain_cnt_d = drain_cnt_q;
        clr         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    clr = 1'b1;
                    if (k_len != '0) begin
                        state_d    = ST_LOAD;
                        beat_cnt_d = k_len;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    beat_cnt_d = beat_cnt_q - KLEN_W'(1);
                    if (beat_cnt_q == KLEN_W'(1)) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DRAIN_LAST;
                    end
                end
            end
            ST_DRAIN: begin
                // Zeros flush the last beat through to the far corner PE.
                if (drain_cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            beat_cnt_q  <= '0;
            drain_cnt_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (ce) begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            in_ready_q  <= (state_d == ST_LOAD);
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

    logic [NUM_SIZE-1:0] h_bus [GRID_SIZE][GRID_SIZE+1];
    logic [NUM_SIZE-1:0] v_bus [GRID_SIZE+1][GRID_SIZE];

    // Lane i enters i cycles late so A[i][k] and B[k][j] meet at PE(i,j).
    for (genvar i = 0; i < GRID_SIZE; i++) begin : g_skew
        logic [NUM_SIZE-1:0] west_lane, north_lane;
        assign west_lane  = beat ? west_input[i*NUM_SIZE +: NUM_SIZE]  : '0;
        assign north_lane = beat ? north_input[i*NUM_SIZE +: NUM_SIZE] : '0;

        if (i == 0) begin : g_direct
            assign h_bus[i][0] = west_lane;
            assign v_bus[0][i] = north_lane;
        end else begin : g_delay
            logic [NUM_SIZE-1:0] west_sk_d  [i];
            logic [NUM_SIZE-1:0] west_sk_q  [i];
            logic [NUM_SIZE-1:0] north_sk_d [i];
            logic [NUM_SIZE-1:0] north_sk_q [i];

            always_comb begin
                west_sk_d[0]  = west_lane;
                north_sk_d[0] = north_lane;
                for (int m = 1; m < i; m++) begin
                    west_sk_d[m]  = west_sk_q[m-1];
                    north_sk_d[m] = north_sk_q[m-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int m = 0; m < i; m++) begin
                        west_sk_q[m]  <= '0;
                        north_sk_q[m] <= '0;
                    end
                end else if (ce) begin
                    west_sk_q  <= west_sk_d;
                    north_sk_q <= north_sk_d;
                end
            end

            assign h_bus[i][0] = west_sk_q[i-1];
            assign v_bus[0][i] = north_sk_q[i-1];
        end
    end

    for (genvar i = 0; i < GRID_SIZE; i++) begin : g_row
        for (genvar j = 0; j < GRID_SIZE; j++) begin : g_col
            mac_pe #(
                .NUM_SIZE (NUM_SIZE),
                .ACC_SIZE (ACC_SIZE)
            ) u_pe (
                .clk     (clk),
                .rst     (rst),
                .ce      (ce),
                .clr     (clr),
                .a_in    (h_bus[i][j]),
                .b_in    (v_bus[i][j]),
                .a_out   (h_bus[i][j+1]),
                .b_out   (v_bus[i+1][j]),
                .acc_out (result_out[(i*GRID_SIZE+j)*ACC_SIZE +: ACC_SIZE])
            );
        end
    end

    // Operands leaving the east and south edges have no consumer.
    logic [GRID_SIZE*NUM_SIZE-1:0] unused_east, unused_south;
    for (genvar i = 0; i < GRID_SIZE; i++) begin : g_edge
        assign unused_east[i*NUM_SIZE +: NUM_SIZE]  = h_bus[i][GRID_SIZE];
        assign unused_south[i*NUM_SIZE +: NUM_SIZE] = v_bus[GRID_SIZE][i];
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_mxu.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_systolic_mxu: directed scoreboard bench for systolic_mxu
// Rev 1.0
// ------------------------------------------------------------------
module tb_systolic_mxu;

    localparam int N   = 16;
    localparam int G   = 4;
    localparam int ACC = 2 * N + 8;
    localparam int KW  = 8;

    typedef logic [G*G*ACC-1:0] res_t;

    logic             clk = 1'b0;
    logic             rst, ce, start, in_valid, out_ready;
    logic [KW-1:0]    k_len;
    logic             in_ready, out_valid, busy;
    logic [G*N-1:0]   west_input, north_input;
    res_t             result_out;

    int   checks = 0;
    int   errors = 0;
    int   ma [G][16];
    int   mb [16][G];
    res_t sb_q [$];

    systolic_mxu #(.NUM_SIZE(N), .GRID_SIZE(G), .ACC_SIZE(ACC), .KLEN_W(KW)) dut (
        .clk         (clk),
        .rst         (rst),
        .ce          (ce),
        .start       (start),
        .k_len       (k_len),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .west_input  (west_input),
        .north_input (north_input),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result_out  (result_out),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input res_t obs, input res_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input int k);
        res_t   r;
        longint sum;
        r = '0;
        for (int i = 0; i < G; i++) begin
            for (int j = 0; j < G; j++) begin
                sum = 0;
                for (int kk = 0; kk < k; kk++) sum += longint'(ma[i][kk]) * longint'(mb[kk][j]);
                r[(i*G+j)*ACC +: ACC] = sum[ACC-1:0];
            end
        end
        return r;
    endfunction

    task automatic drive_beat(input int k);
        for (int i = 0; i < G; i++) begin
            west_input[i*N +: N]  = N'(ma[i][k]);
            north_input[i*N +: N] = N'(mb[k][i]);
        end
    endtask

    task automatic check_result(input string tag);
        res_t exp;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_scoreboard: observed empty queue expected entry", tag);
        end else begin
            exp = sb_q.pop_front();
            for (int n = 0; n < G*G; n++)
                chk($sformatf("%s_c%0d", tag, n), res_t'(result_out[n*ACC +: ACC]), res_t'(exp[n*ACC +: ACC]));
        end
    endtask

    task automatic release_result(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_ovalid_clr"}, res_t'(out_valid), res_t'(0));
        chk({tag, "_busy_clr"}, res_t'(busy), res_t'(0));
    endtask

    task automatic wait_result(input string tag, input int ce_gap, input int exp_lat);
        int lat;
        lat = 1;
        while (!out_valid && lat < 200) begin
            if (ce_gap > 0 && lat == 3) begin
                ce = 1'b0;
                repeat (ce_gap) @(negedge clk);
                ce = 1'b1;
                lat += ce_gap;
            end
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, res_t'(lat), res_t'(exp_lat));
        check_result(tag);
        release_result(tag);
    endtask

    task automatic run_product(input string tag, input int k, input int bubble_after,
                               input int ce_gap, input int exp_lat);
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(k);
        sb_q.push_back(model(k));
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_in_ready"}, res_t'(in_ready), res_t'(1));
        chk({tag, "_busy"}, res_t'(busy), res_t'(1));
        for (int b = 0; b < k; b++) begin
            drive_beat(b);
            in_valid = 1'b1;
            @(negedge clk);
            if (b == bubble_after) begin
                in_valid    = 1'b0;
                west_input  = {$urandom, $urandom};
                north_input = {$urandom, $urandom};
                @(negedge clk);
            end
        end
        in_valid    = 1'b0;
        west_input  = '0;
        north_input = '0;
        wait_result(tag, ce_gap, exp_lat);
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        k_len = '0; west_input = '0; north_input = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", res_t'(busy), res_t'(0));
        chk("rst_in_ready", res_t'(in_ready), res_t'(0));
        chk("rst_out_valid", res_t'(out_valid), res_t'(0));
        chk("rst_result", result_out, '0);

        // Identity A: C must equal B.
        for (int i = 0; i < G; i++)
            for (int k = 0; k < G; k++) begin
                ma[i][k] = (i == k) ? 1 : 0;
                mb[k][i] = k * 4 + i + 1;
            end
        run_product("ident", 4, -1, 0, 2*G);

        // All ones, K=3, bubble after the first beat.
        for (int i = 0; i < G; i++)
            for (int k = 0; k < 16; k++) begin ma[i][k] = 1; mb[k][i] = 1; end
        run_product("bubble", 3, 0, 0, 2*G);

        // Negative operands: every element -10, sign-extended.
        for (int i = 0; i < G; i++)
            for (int k = 0; k < 16; k++) begin ma[i][k] = -1; mb[k][i] = 2; end
        run_product("neg", 5, -1, 0, 2*G);

        // K=0: immediate DONE with zero result, held while out_ready is low.
        @(negedge clk);
        start = 1'b1;
        k_len = '0;
        sb_q.push_back('0);
        @(negedge clk);
        start = 1'b0;
        chk("k0_out_valid", res_t'(out_valid), res_t'(1));
        for (int c = 0; c < 10; c++) begin
            start = (c == 4);
            k_len = KW'(3);
            @(negedge clk);
            chk($sformatf("k0_hold_valid%0d", c), res_t'(out_valid), res_t'(1));
            chk($sformatf("k0_hold_busy%0d", c), res_t'(busy), res_t'(1));
            chk($sformatf("k0_hold_result%0d", c), result_out, '0);
        end
        start = 1'b0;
        check_result("k0");
        release_result("k0");

        // Reset mid-LOAD after 2 of 4 beats.
        for (int i = 0; i < G; i++)
            for (int k = 0; k < 16; k++) begin ma[i][k] = i + k + 2; mb[k][i] = 5 - k; end
        @(negedge clk);
        start = 1'b1;
        k_len = KW'(4);
        @(negedge clk);
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            drive_beat(b);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", res_t'(busy), res_t'(0));
        chk("abort_in_ready", res_t'(in_ready), res_t'(0));
        chk("abort_out_valid", res_t'(out_valid), res_t'(0));
        chk("abort_result", result_out, '0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < G; i++)
            for (int k = 0; k < 16; k++) begin ma[i][k] = 3; mb[k][i] = 4; end
        run_product("after_rst", 1, -1, 0, 2*G);

        // Random operands, run plain and then with ce low for 5 DRAIN cycles.
        for (int i = 0; i < G; i++)
            for (int k = 0; k < 16; k++) begin
                ma[i][k] = int'($urandom_range(0, 60000)) - 30000;
                mb[k][i] = int'($urandom_range(0, 60000)) - 30000;
            end
        run_product("rand", 4, -1, 0, 2*G);
        run_product("ce_gap", 4, 1, 5, 2*G + 5);

        chk("sb_empty", res_t'(sb_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
